rom_stream_loader: RTL

- Sequential reader that sits directly downstream of the synchronous test/boot ROM model (1-cycle read latency, 22-bit byte address).
- Walks ROM addresses 0..ROM_SIZE-1 and streams each byte with its address over a valid/ready interface toward the SDRAM cart-memory writer.
- While streaming, captures the cartridge header map-mode byte and decodes HiROM/FastROM for the memory mapper.

---
 rtl/rom_loader_pkg.sv | 31 +++
 rtl/rom_header_capture.sv | 69 ++++++
 rtl/rom_stream_loader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rom_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rom_loader_pkg
// Purpose  : Shared types and constants for the ROM stream loader:
//            loader FSM state encoding, cartridge header byte offsets and
//            map-mode bit positions.
// Optional : ROM_LOADER_CHECKSUM_EN (used by the loader and header capture)
// Revision : 1.0 - initial release
// ============================================================================
package rom_loader_pkg;

    localparam int ADDR_W = 22;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_EMIT = 2'd3
    } state_t;

    // Byte offsets inside the cartridge header
    localparam logic [5:0] HDR_MAPMODE_OFS = 6'h15;
    localparam logic [5:0] HDR_SUM_LO_OFS  = 6'h1E;
    localparam logic [5:0] HDR_SUM_HI_OFS  = 6'h1F;

    // Map-mode byte bit positions
    localparam int MM_HIROM_BIT = 0;
    localparam int MM_FAST_BIT  = 4;

endpackage : rom_loader_pkg
`default_nettype wire

// File: rtl/rom_header_capture.sv
`default_nettype none
// ============================================================================
// Module   : rom_header_capture
// Purpose  : Watches the byte stream as it is read from ROM and latches the
//            cartridge header map-mode byte (and, when enabled, the 16-bit
//            header checksum).
// Ports    : clk, resetn      - clock, async active-low reset
//            cap_en           - a ROM byte is being latched this cycle
//            cap_addr         - address of that byte
//            cap_data         - the byte itself
//            map_mode         - captured map-mode byte (retained until
//                               recaptured or reset)
//            hdr_sum          - captured header checksum (optional)
// Optional : ROM_LOADER_CHECKSUM_EN adds the hdr_sum output
// Revision : 1.0 - initial release
// ============================================================================
module rom_header_capture
    import rom_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] HDR_BASE = 22'h7FC0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cap_en,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic [7:0]        cap_data,
    output logic [7:0]        map_mode
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]       hdr_sum
`endif
);

    // A header address beyond the streamed range is simply never matched,
    // so the captured values stay at their reset value.
    localparam logic [ADDR_W-1:0] c_mm_addr = HDR_BASE + ADDR_W'(HDR_MAPMODE_OFS);

    logic [7:0] r_map_mode;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_map_mode <= 8'h00;
        end else if (cap_en && (cap_addr == c_mm_addr)) begin
            r_map_mode <= cap_data;
        end
    end

    assign map_mode = r_map_mode;

`ifdef ROM_LOADER_CHECKSUM_EN
    localparam logic [ADDR_W-1:0] c_sum_lo_addr = HDR_BASE + ADDR_W'(HDR_SUM_LO_OFS);
    localparam logic [ADDR_W-1:0] c_sum_hi_addr = HDR_BASE + ADDR_W'(HDR_SUM_HI_OFS);

    logic [15:0] r_hdr_sum;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hdr_sum <= 16'h0000;
        end else if (cap_en) begin
            if (cap_addr == c_sum_lo_addr) r_hdr_sum[7:0]  <= cap_data;
            if (cap_addr == c_sum_hi_addr) r_hdr_sum[15:8] <= cap_data;
        end
    end

    assign hdr_sum = r_hdr_sum;
`endif

endmodule : rom_header_capture
`default_nettype wire

// File: rtl/rom_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : rom_stream_loader
// Purpose  : Reads ROM addresses 0..ROM_SIZE-1 from a 1-cycle-latency
//            synchronous ROM and streams every byte with its address over a
//            valid/ready interface. Decodes HiROM/FastROM from the captured
//            cartridge header map-mode byte.
// Ports    : clk, resetn          - clock, async active-low reset
//            start                - pulse, begins a load when idle
//            rom_addr / rom_dout  - ROM read port
//            dout, dout_addr,
//            dout_valid/ready     - byte stream toward the cart-memory writer
//            busy, done           - load in progress / sticky completion
//            map_mode, hirom,
//            fastrom              - header decode
//            checksum,
//            checksum_ok          - running byte sum / match (optional)
// Optional : ROM_LOADER_CHECKSUM_EN adds checksum and checksum_ok
// Revision : 1.0 - initial release
// ============================================================================
module rom_stream_loader
    import rom_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ROM_SIZE = 22'h8000,
    parameter logic [ADDR_W-1:0] HDR_BASE = 22'h7FC0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_dout,
    output logic [7:0]        dout,
    output logic [ADDR_W-1:0] dout_addr,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done,
    output logic [7:0]        map_mode,
    output logic              hirom,
    output logic              fastrom
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum,
    output logic              checksum_ok
`endif
);

    localparam logic [ADDR_W-1:0] c_last_addr = ROM_SIZE - 22'd1;

    state_t            r_state,      w_state_nxt;
    logic [ADDR_W-1:0] r_cur_addr,   w_cur_addr_nxt;
    logic [ADDR_W-1:0] r_rom_addr,   w_rom_addr_nxt;
    logic [7:0]        r_dout,       w_dout_nxt;
    logic [ADDR_W-1:0] r_dout_addr,  w_dout_addr_nxt;
    logic              r_dout_valid, w_dout_valid_nxt;
    logic              r_busy,       w_busy_nxt;
    logic              r_done,       w_done_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_cur_addr   <= '0;
            r_rom_addr   <= '0;
            r_dout       <= 8'h00;
            r_dout_addr  <= '0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_addr   <= w_cur_addr_nxt;
            r_rom_addr   <= w_rom_addr_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_addr  <= w_dout_addr_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    // rom_addr is loaded on the transition into ADDR so the ROM samples it at
    // the end of the ADDR cycle and its data is present during DATA.
    always_comb begin
        w_state_nxt      = r_state;
        w_cur_addr_nxt   = r_cur_addr;
        w_rom_addr_nxt   = r_rom_addr;
        w_dout_nxt       = r_dout;
        w_dout_addr_nxt  = r_dout_addr;
        w_dout_valid_nxt = r_dout_valid;
        w_busy_nxt       = r_busy;
        w_done_nxt       = r_done;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_cur_addr_nxt = '0;
                    w_rom_addr_nxt = '0;
                    w_busy_nxt     = 1'b1;
                    w_done_nxt     = 1'b0;
                    w_state_nxt    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                w_dout_nxt       = rom_dout;
                w_dout_addr_nxt  = r_cur_addr;
                w_dout_valid_nxt = 1'b1;
                w_state_nxt      = ST_EMIT;
            end
            ST_EMIT: begin
                if (dout_ready) begin
                    w_dout_valid_nxt = 1'b0;
                    if (r_cur_addr == c_last_addr) begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cur_addr_nxt = r_cur_addr + 22'd1;
                        w_rom_addr_nxt = r_cur_addr + 22'd1;
                        w_state_nxt    = ST_ADDR;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign rom_addr   = r_rom_addr;
    assign dout       = r_dout;
    assign dout_addr  = r_dout_addr;
    assign dout_valid = r_dout_valid;
    assign busy       = r_busy;
    assign done       = r_done;

    logic w_cap_en;
    assign w_cap_en = (r_state == ST_DATA);

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0] w_hdr_sum;
`endif

    rom_header_capture #(
        .HDR_BASE (HDR_BASE)
    ) u_hdr (
        .clk      (clk),
        .resetn   (resetn),
        .cap_en   (w_cap_en),
        .cap_addr (r_cur_addr),
        .cap_data (rom_dout),
        .map_mode (map_mode)
`ifdef ROM_LOADER_CHECKSUM_EN
        ,
        .hdr_sum  (w_hdr_sum)
`endif
    );

    assign hirom   = map_mode[MM_HIROM_BIT];
    assign fastrom = map_mode[MM_FAST_BIT];

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0] r_checksum;
    logic        w_handshake;
    logic        w_start_acc;

    assign w_handshake = r_dout_valid && dout_ready;
    assign w_start_acc = (r_state == ST_IDLE) && start;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_checksum <= 16'h0000;
        end else if (w_start_acc) begin
            r_checksum <= 16'h0000;
        end else if (w_handshake) begin
            r_checksum <= r_checksum + {8'h00, r_dout};
        end
    end

    assign checksum    = r_checksum;
    assign checksum_ok = r_done && (r_checksum == w_hdr_sum);
`endif

endmodule : rom_stream_loader
`default_nettype wire
